// File: rtl/bus_arbiter.sv
// bus_arbiter: shares one memory bus between IFU reads and LSU reads/writes.
// Handles one outstanding transaction at a time and routes each response
// back to its owner as a one-cycle pulse.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   ifu_ar*/ifu_r*      IFU read request / response
//   lsu_ar*/lsu_r*      LSU read request / response
//   lsu_aw*/lsu_w*/lsu_bvalid  LSU write request / response
//   mem_*               downstream bus master port
//   owner               current grant (00 none, 01 IFU, 10 LSU)
// Build option: define ARB_RR_EN for round-robin IFU/LSU arbitration;
// fixed LSU priority otherwise.
module bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_W-1:0]     ifu_araddr,
  input  logic                  ifu_arvalid,
  output logic [DATA_W-1:0]     ifu_rdata,
  output logic                  ifu_rvalid,
  input  logic [ADDR_W-1:0]     lsu_araddr,
  input  logic                  lsu_arvalid,
  output logic [DATA_W-1:0]     lsu_rdata,
  output logic                  lsu_rvalid,
  input  logic [ADDR_W-1:0]     lsu_awaddr,
  input  logic                  lsu_awvalid,
  input  logic [DATA_W-1:0]     lsu_wdata,
  input  logic [DATA_W/8-1:0]   lsu_wstrb,
  output logic                  lsu_bvalid,
  output logic [ADDR_W-1:0]     mem_araddr,
  output logic                  mem_arvalid,
  input  logic                  mem_arready,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_rvalid,
  output logic [ADDR_W-1:0]     mem_awaddr,
  output logic                  mem_awvalid,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_wstrb,
  input  logic                  mem_awready,
  input  logic                  mem_bvalid,
  output logic [1:0]            owner
);

  localparam int STRB_W = DATA_W / 8;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_IFU  = 2'b01;
  localparam logic [1:0] OWN_LSU  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RADDR,
    S_RDATA,
    S_WADDR,
    S_WRESP
  } state_t;

  state_t              r_state;
  logic [1:0]          r_owner;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [STRB_W-1:0]   r_wstrb;
  logic                r_arvalid;
  logic                r_awvalid;

  logic                w_lsu_req;
  logic                w_grant_lsu;
  logic                w_grant_ifu;
  logic                w_rd_fire;
  logic                w_wr_fire;

  assign w_lsu_req = lsu_awvalid | lsu_arvalid;

`ifdef ARB_RR_EN
  // Set when the LSU was granted last; reset value means IFU-last.
  logic r_last_lsu;

  // On contention the requester not served last wins.
  assign w_grant_lsu = w_lsu_req &&
                       (!ifu_arvalid || !r_last_lsu);
`else
  assign w_grant_lsu = w_lsu_req;
`endif

  assign w_grant_ifu = ifu_arvalid && !w_grant_lsu;

  // A read completes in RDATA, or in RADDR when data comes
  // back in the same cycle as the address is accepted.
  assign w_rd_fire = !rst && mem_rvalid &&
                     ((r_state == S_RDATA) ||
                      ((r_state == S_RADDR) && mem_arready));

  assign w_wr_fire = !rst && mem_bvalid &&
                     ((r_state == S_WRESP) ||
                      ((r_state == S_WADDR) && mem_awready));

  assign ifu_rvalid = w_rd_fire && (r_owner == OWN_IFU);
  assign lsu_rvalid = w_rd_fire && (r_owner == OWN_LSU);
  assign lsu_bvalid = w_wr_fire;

  assign ifu_rdata = ifu_rvalid ? mem_rdata : '0;
  assign lsu_rdata = lsu_rvalid ? mem_rdata : '0;

  assign mem_araddr  = r_addr;
  assign mem_awaddr  = r_addr;
  assign mem_wdata   = r_wdata;
  assign mem_wstrb   = r_wstrb;
  assign mem_arvalid = r_arvalid;
  assign mem_awvalid = r_awvalid;
  assign owner       = r_owner;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_owner   <= OWN_NONE;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_arvalid <= 1'b0;
      r_awvalid <= 1'b0;
`ifdef ARB_RR_EN
      r_last_lsu <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant_lsu) begin
            r_owner <= OWN_LSU;
`ifdef ARB_RR_EN
            r_last_lsu <= 1'b1;
`endif
            // Writes go ahead of reads within the LSU.
            if (lsu_awvalid) begin
              r_addr    <= lsu_awaddr;
              r_wdata   <= lsu_wdata;
              r_wstrb   <= lsu_wstrb;
              r_awvalid <= 1'b1;
              r_state   <= S_WADDR;
            end else begin
              r_addr    <= lsu_araddr;
              r_arvalid <= 1'b1;
              r_state   <= S_RADDR;
            end
          end else if (w_grant_ifu) begin
            r_owner   <= OWN_IFU;
            r_addr    <= ifu_araddr;
            r_arvalid <= 1'b1;
            r_state   <= S_RADDR;
`ifdef ARB_RR_EN
            r_last_lsu <= 1'b0;
`endif
          end
        end
        S_RADDR: begin
          if (mem_arready) begin
            r_arvalid <= 1'b0;
            if (mem_rvalid) begin
              r_owner <= OWN_NONE;
              r_state <= S_IDLE;
            end else begin
              r_state <= S_RDATA;
            end
          end
        end
        S_RDATA: begin
          if (mem_rvalid) begin
            r_owner <= OWN_NONE;
            r_state <= S_IDLE;
          end
        end
        S_WADDR: begin
          if (mem_awready) begin
            r_awvalid <= 1'b0;
            if (mem_bvalid) begin
              r_owner <= OWN_NONE;
              r_state <= S_IDLE;
            end else begin
              r_state <= S_WRESP;
            end
          end
        end
        S_WRESP: begin
          if (mem_bvalid) begin
            r_owner <= OWN_NONE;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_owner   <= OWN_NONE;
          r_arvalid <= 1'b0;
          r_awvalid <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed self-checking bench for bus_arbiter.
// Inputs driven 1ns after posedge, outputs sampled on negedge.
module tb_bus_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] ifu_araddr;
  logic          ifu_arvalid;
  logic [DW-1:0] ifu_rdata;
  logic          ifu_rvalid;
  logic [AW-1:0] lsu_araddr;
  logic          lsu_arvalid;
  logic [DW-1:0] lsu_rdata;
  logic          lsu_rvalid;
  logic [AW-1:0] lsu_awaddr;
  logic          lsu_awvalid;
  logic [DW-1:0] lsu_wdata;
  logic [3:0]    lsu_wstrb;
  logic          lsu_bvalid;
  logic [AW-1:0] mem_araddr;
  logic          mem_arvalid;
  logic          mem_arready;
  logic [DW-1:0] mem_rdata;
  logic          mem_rvalid;
  logic [AW-1:0] mem_awaddr;
  logic          mem_awvalid;
  logic [DW-1:0] mem_wdata;
  logic [3:0]    mem_wstrb;
  logic          mem_awready;
  logic          mem_bvalid;
  logic [1:0]    owner;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bus_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .ifu_araddr  (ifu_araddr),
    .ifu_arvalid (ifu_arvalid),
    .ifu_rdata   (ifu_rdata),
    .ifu_rvalid  (ifu_rvalid),
    .lsu_araddr  (lsu_araddr),
    .lsu_arvalid (lsu_arvalid),
    .lsu_rdata   (lsu_rdata),
    .lsu_rvalid  (lsu_rvalid),
    .lsu_awaddr  (lsu_awaddr),
    .lsu_awvalid (lsu_awvalid),
    .lsu_wdata   (lsu_wdata),
    .lsu_wstrb   (lsu_wstrb),
    .lsu_bvalid  (lsu_bvalid),
    .mem_araddr  (mem_araddr),
    .mem_arvalid (mem_arvalid),
    .mem_arready (mem_arready),
    .mem_rdata   (mem_rdata),
    .mem_rvalid  (mem_rvalid),
    .mem_awaddr  (mem_awaddr),
    .mem_awvalid (mem_awvalid),
    .mem_wdata   (mem_wdata),
    .mem_wstrb   (mem_wstrb),
    .mem_awready (mem_awready),
    .mem_bvalid  (mem_bvalid),
    .owner       (owner)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc();
    cyc();
    @(negedge clk);
    n_cmp++; if (owner !== 2'b00) begin n_err++;
      $display("FAIL rst_owner got %h want 00", owner); end
    n_cmp++; if (mem_arvalid !== 1'b0 || mem_awvalid !== 1'b0) begin n_err++;
      $display("FAIL rst_valid got %b%b want 00", mem_arvalid, mem_awvalid); end
    n_cmp++; if (ifu_rvalid !== 1'b0 || lsu_rvalid !== 1'b0 || lsu_bvalid !== 1'b0) begin n_err++;
      $display("FAIL rst_pulse got %b%b%b want 000", ifu_rvalid, lsu_rvalid, lsu_bvalid); end
    n_cmp++; if (mem_araddr !== 32'h0 || mem_wdata !== 32'h0 || mem_wstrb !== 4'h0) begin n_err++;
      $display("FAIL rst_regs got %h %h %h want 0", mem_araddr, mem_wdata, mem_wstrb); end
    cyc();
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (owner !== 2'b00) begin n_err++;
      $display("FAIL rst_idle_owner got %h want 00", owner); end
  endtask

  task automatic test_ifu_only();
    cyc();
    ifu_araddr = 32'h8000_0000; ifu_arvalid = 1'b1;
    @(negedge clk);
    n_cmp++; if (mem_arvalid !== 1'b0 || owner !== 2'b00) begin n_err++;
      $display("FAIL ifu_c0 got arv=%b own=%h want 0 00", mem_arvalid, owner); end
    cyc();
    @(negedge clk);
    n_cmp++; if (mem_arvalid !== 1'b1 || owner !== 2'b01) begin n_err++;
      $display("FAIL ifu_c1 got arv=%b own=%h want 1 01", mem_arvalid, owner); end
    n_cmp++; if (mem_araddr !== 32'h8000_0000) begin n_err++;
      $display("FAIL ifu_araddr got %h want 80000000", mem_araddr); end
    cyc();
    mem_arready = 1'b1;
    @(negedge clk);
    n_cmp++; if (mem_arvalid !== 1'b1) begin n_err++;
      $display("FAIL ifu_c2_arv got %b want 1", mem_arvalid); end
    cyc();
    mem_arready = 1'b0;
    @(negedge clk);
    n_cmp++; if (mem_arvalid !== 1'b0 || owner !== 2'b01 || ifu_rvalid !== 1'b0) begin n_err++;
      $display("FAIL ifu_c3 got arv=%b own=%h rv=%b want 0 01 0", mem_arvalid, owner, ifu_rvalid); end
    cyc();
    mem_rvalid = 1'b1; mem_rdata = 32'h0000_0413;
    @(negedge clk);
    n_cmp++; if (ifu_rvalid !== 1'b1 || ifu_rdata !== 32'h0000_0413) begin n_err++;
      $display("FAIL ifu_resp got %b %h want 1 00000413", ifu_rvalid, ifu_rdata); end
    n_cmp++; if (lsu_rvalid !== 1'b0 || lsu_rdata !== 32'h0 || owner !== 2'b01) begin n_err++;
      $display("FAIL ifu_c4_other got %b %h own=%h want 0 0 01", lsu_rvalid, lsu_rdata, owner); end
    cyc();
    mem_rvalid = 1'b0; mem_rdata = 32'h0; ifu_arvalid = 1'b0;
    @(negedge clk);
    n_cmp++; if (owner !== 2'b00 || ifu_rvalid !== 1'b0 || ifu_rdata !== 32'h0) begin n_err++;
      $display("FAIL ifu_c5 got own=%h rv=%b rd=%h want 00 0 0", owner, ifu_rvalid, ifu_rdata); end
  endtask

  task automatic test_lsu_write();
    cyc();
    lsu_awaddr = 32'hA000_0000; lsu_wdata = 32'hDEAD_BEEF;
    lsu_wstrb = 4'hF; lsu_awvalid = 1'b1;
    @(negedge clk);
    n_cmp++; if (owner !== 2'b00 || mem_awvalid !== 1'b0) begin n_err++;
      $display("FAIL wr_c0 got own=%h awv=%b want 00 0", owner, mem_awvalid); end
    for (int i = 1; i <= 3; i++) begin
      cyc();
      lsu_awaddr = 32'h1111_0000 + i;
      lsu_wdata = 32'h1234_5678 + i;
      lsu_wstrb = 4'h1;
      @(negedge clk);
      n_cmp++; if (mem_awvalid !== 1'b1 || owner !== 2'b10) begin n_err++;
        $display("FAIL wr_hold%0d got awv=%b own=%h want 1 10", i, mem_awvalid, owner); end
      n_cmp++; if (mem_awaddr !== 32'hA000_0000 || mem_wdata !== 32'hDEAD_BEEF || mem_wstrb !== 4'hF) begin
        n_err++;
        $display("FAIL wr_stable%0d got %h %h %h want a0000000 deadbeef f", i, mem_awaddr, mem_wdata, mem_wstrb); end
    end
    cyc();
    mem_awready = 1'b1;
    @(negedge clk);
    n_cmp++; if (mem_awvalid !== 1'b1 || lsu_bvalid !== 1'b0) begin n_err++;
      $display("FAIL wr_c4 got awv=%b bv=%b want 1 0", mem_awvalid, lsu_bvalid); end
    cyc();
    mem_awready = 1'b0;
    @(negedge clk);
    n_cmp++; if (mem_awvalid !== 1'b0 || lsu_bvalid !== 1'b0 || owner !== 2'b10) begin n_err++;
      $display("FAIL wr_c5 got awv=%b bv=%b own=%h want 0 0 10", mem_awvalid, lsu_bvalid, owner); end
    cyc();
    mem_bvalid = 1'b1;
    @(negedge clk);
    n_cmp++; if (lsu_bvalid !== 1'b1 || ifu_rvalid !== 1'b0 || lsu_rvalid !== 1'b0) begin n_err++;
      $display("FAIL wr_resp got bv=%b irv=%b lrv=%b want 1 0 0", lsu_bvalid, ifu_rvalid, lsu_rvalid); end
    cyc();
    mem_bvalid = 1'b0; lsu_awvalid = 1'b0;
    @(negedge clk);
    n_cmp++; if (lsu_bvalid !== 1'b0 || owner !== 2'b00) begin n_err++;
      $display("FAIL wr_c7 got bv=%b own=%h want 0 00", lsu_bvalid, owner); end
  endtask

  // Both request at once; the LSU has been granted last here.
  task automatic test_arbitration();
    logic          ifu_first;
    logic [1:0]    o1, o2;
    logic [31:0]   a1, a2;
    logic [31:0]   e_id, e_ld;
`ifdef ARB_RR_EN
    ifu_first = 1'b1;
`else
    ifu_first = 1'b0;
`endif
    o1 = ifu_first ? 2'b01 : 2'b10;
    o2 = ifu_first ? 2'b10 : 2'b01;
    a1 = ifu_first ? 32'h8000_0004 : 32'h8000_1000;
    a2 = ifu_first ? 32'h8000_1000 : 32'h8000_0004;
    cyc();
    ifu_araddr = 32'h8000_0004; ifu_arvalid = 1'b1;
    lsu_araddr = 32'h8000_1000; lsu_arvalid = 1'b1;
    @(negedge clk);
    cyc();
    @(negedge clk);
    n_cmp++; if (owner !== o1 || mem_araddr !== a1 || mem_arvalid !== 1'b1) begin n_err++;
      $display("FAIL arb_first got own=%h a=%h v=%b want %h %h 1", owner, mem_araddr, mem_arvalid, o1, a1); end
    cyc();
    mem_arready = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h1111_1111;
    e_id = ifu_first ? 32'h1111_1111 : 32'h0;
    e_ld = ifu_first ? 32'h0 : 32'h1111_1111;
    @(negedge clk);
    n_cmp++; if (ifu_rvalid !== ifu_first || lsu_rvalid !== !ifu_first) begin n_err++;
      $display("FAIL arb_resp1 got i=%b l=%b want %b %b", ifu_rvalid, lsu_rvalid, ifu_first, !ifu_first); end
    n_cmp++; if (ifu_rdata !== e_id || lsu_rdata !== e_ld) begin n_err++;
      $display("FAIL arb_data1 got %h %h want %h %h", ifu_rdata, lsu_rdata, e_id, e_ld); end
    cyc();
    mem_arready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    if (ifu_first) ifu_arvalid = 1'b0;
    else lsu_arvalid = 1'b0;
    @(negedge clk);
    n_cmp++; if (owner !== 2'b00 || mem_arvalid !== 1'b0) begin n_err++;
      $display("FAIL arb_idle got own=%h v=%b want 00 0", owner, mem_arvalid); end
    cyc();
    @(negedge clk);
    n_cmp++; if (owner !== o2 || mem_araddr !== a2 || mem_arvalid !== 1'b1) begin n_err++;
      $display("FAIL arb_second got own=%h a=%h v=%b want %h %h 1", owner, mem_araddr, mem_arvalid, o2, a2); end
    cyc();
    mem_arready = 1'b1;
    @(negedge clk);
    cyc();
    mem_arready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h2222_2222;
    e_id = ifu_first ? 32'h0 : 32'h2222_2222;
    e_ld = ifu_first ? 32'h2222_2222 : 32'h0;
    @(negedge clk);
    n_cmp++; if (ifu_rvalid !== !ifu_first || lsu_rvalid !== ifu_first) begin n_err++;
      $display("FAIL arb_resp2 got i=%b l=%b want %b %b", ifu_rvalid, lsu_rvalid, !ifu_first, ifu_first); end
    n_cmp++; if (ifu_rdata !== e_id || lsu_rdata !== e_ld) begin n_err++;
      $display("FAIL arb_data2 got %h %h want %h %h", ifu_rdata, lsu_rdata, e_id, e_ld); end
    cyc();
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    ifu_arvalid = 1'b0; lsu_arvalid = 1'b0;
    @(negedge clk);
    n_cmp++; if (owner !== 2'b00) begin n_err++;
      $display("FAIL arb_end got own=%h want 00", owner); end
  endtask

  task automatic test_same_cycle();
    cyc();
    mem_rvalid = 1'b1; mem_bvalid = 1'b1; mem_rdata = 32'hDEAD_0000;
    @(negedge clk);
    n_cmp++; if (ifu_rvalid !== 1'b0 || lsu_rvalid !== 1'b0 || lsu_bvalid !== 1'b0) begin n_err++;
      $display("FAIL spur_idle got %b%b%b want 000", ifu_rvalid, lsu_rvalid, lsu_bvalid); end
    n_cmp++; if (ifu_rdata !== 32'h0 || owner !== 2'b00) begin n_err++;
      $display("FAIL spur_idle_data got %h own=%h want 0 00", ifu_rdata, owner); end
    cyc();
    mem_rvalid = 1'b0; mem_bvalid = 1'b0; mem_rdata = 32'h0;
    lsu_awaddr = 32'hA000_0010; lsu_wdata = 32'h0BAD_F00D;
    lsu_wstrb = 4'h3; lsu_awvalid = 1'b1;
    @(negedge clk);
    cyc();
    mem_awready = 1'b1; mem_bvalid = 1'b1;
    @(negedge clk);
    n_cmp++; if (lsu_bvalid !== 1'b1 || mem_awvalid !== 1'b1 || mem_wstrb !== 4'h3) begin n_err++;
      $display("FAIL wr_same got bv=%b awv=%b s=%h want 1 1 3", lsu_bvalid, mem_awvalid, mem_wstrb); end
    cyc();
    mem_awready = 1'b0; mem_bvalid = 1'b0; lsu_awvalid = 1'b0;
    @(negedge clk);
    n_cmp++; if (owner !== 2'b00 || mem_awvalid !== 1'b0 || lsu_bvalid !== 1'b0) begin n_err++;
      $display("FAIL wr_same_end got own=%h awv=%b bv=%b want 00 0 0", owner, mem_awvalid, lsu_bvalid); end
  endtask

  task automatic test_reset_mid();
    cyc();
    ifu_araddr = 32'h8000_0020; ifu_arvalid = 1'b1;
    @(negedge clk);
    cyc();
    mem_rvalid = 1'b1; mem_rdata = 32'h0000_0077;
    @(negedge clk);
    n_cmp++; if (ifu_rvalid !== 1'b0 || mem_arvalid !== 1'b1) begin n_err++;
      $display("FAIL spur_raddr got rv=%b arv=%b want 0 1", ifu_rvalid, mem_arvalid); end
    cyc();
    mem_rvalid = 1'b0; mem_rdata = 32'h0; mem_arready = 1'b1;
    @(negedge clk);
    cyc();
    mem_arready = 1'b0;
    @(negedge clk);
    n_cmp++; if (owner !== 2'b01 || mem_arvalid !== 1'b0) begin n_err++;
      $display("FAIL mid_rdata got own=%h arv=%b want 01 0", owner, mem_arvalid); end
    cyc();
    rst = 1'b1; ifu_arvalid = 1'b0;
    @(negedge clk);
    cyc();
    rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0099;
    @(negedge clk);
    n_cmp++; if (owner !== 2'b00 || mem_arvalid !== 1'b0) begin n_err++;
      $display("FAIL mid_rst got own=%h arv=%b want 00 0", owner, mem_arvalid); end
    n_cmp++; if (ifu_rvalid !== 1'b0 || ifu_rdata !== 32'h0) begin n_err++;
      $display("FAIL mid_rst_resp got rv=%b rd=%h want 0 0", ifu_rvalid, ifu_rdata); end
    cyc();
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    @(negedge clk);
    n_cmp++; if (owner !== 2'b00 || ifu_rvalid !== 1'b0) begin n_err++;
      $display("FAIL mid_end got own=%h rv=%b want 00 0", owner, ifu_rvalid); end
  endtask

  initial begin
    rst = 1'b1;
    ifu_araddr = '0; ifu_arvalid = 1'b0;
    lsu_araddr = '0; lsu_arvalid = 1'b0;
    lsu_awaddr = '0; lsu_awvalid = 1'b0;
    lsu_wdata = '0; lsu_wstrb = '0;
    mem_arready = 1'b0; mem_rdata = '0; mem_rvalid = 1'b0;
    mem_awready = 1'b0; mem_bvalid = 1'b0;
    test_reset();
    test_ifu_only();
    test_lsu_write();
    test_arbitration();
    test_same_cycle();
    test_reset_mid();
    cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
